// File: rtl/bridge_arbiter.sv
// -----------------------------------------------------------------------------
// bridge_arbiter
//
// Shares the SoC's external Avalon bridge port between two requesters:
//   m0 - display frame reader
//   m1 - game draw engine
// One bus transaction at a time, round-robin on contention. Each requester gets
// its own one-cycle acknowledge and a read-data register that holds until that
// port's next acknowledge. A watchdog forces completion if the bridge never
// acknowledges; the sticky timeout_flag records that it happened.
//
// Ports:
//   clk_clk, reset_reset           clock, synchronous active-high reset
//   mN_address/byte_enable/read/write/write_data   requester N request
//   mN_acknowledge, mN_read_data   requester N completion pulse and data
//   bridge_memory_*                bus-side request/response
//   grant                          one-hot owner of current transaction
//   timeout_flag                   sticky: some transaction timed out
// -----------------------------------------------------------------------------
module bridge_arbiter #(
    parameter int ADDR_W         = 27,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byte_enable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_write_data,
    output logic                  m0_acknowledge,
    output logic [DATA_W-1:0]     m0_read_data,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byte_enable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_write_data,
    output logic                  m1_acknowledge,
    output logic [DATA_W-1:0]     m1_read_data,

    output logic [ADDR_W-1:0]     bridge_memory_address,
    output logic [DATA_W/8-1:0]   bridge_memory_byte_enable,
    output logic                  bridge_memory_read,
    output logic                  bridge_memory_write,
    output logic [DATA_W-1:0]     bridge_memory_write_data,
    input  logic                  bridge_memory_acknowledge,
    input  logic [DATA_W-1:0]     bridge_memory_read_data,

    output logic [1:0]            grant,
    output logic                  timeout_flag
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [BE_W-1:0]     be_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                bus_read_reg;
    logic                bus_write_reg;
    logic [1:0]          grant_reg;
    logic                last_grant_reg;   // index of the most recently granted port
    logic [CNT_W-1:0]    cnt_reg;
    logic [1:0]          ack_reg;
    logic [DATA_W-1:0]   rdata_reg [2];
    logic                timeout_reg;

    // Requester views as per-port arrays so the winner can be selected by index.
    logic [ADDR_W-1:0]   req_addr  [2];
    logic [BE_W-1:0]     req_be    [2];
    logic [DATA_W-1:0]   req_wdata [2];
    logic [1:0]          req_read;
    logic [1:0]          req_write;
    logic [1:0]          pending;
    logic                winner;

    assign req_addr[0]  = m0_address;
    assign req_addr[1]  = m1_address;
    assign req_be[0]    = m0_byte_enable;
    assign req_be[1]    = m1_byte_enable;
    assign req_wdata[0] = m0_write_data;
    assign req_wdata[1] = m1_write_data;
    assign req_read     = {m1_read, m0_read};
    assign req_write    = {m1_write, m0_write};
    assign pending      = req_read | req_write;

    // On a tie the port that was not served last wins; otherwise the lone requester.
    assign winner = (pending == 2'b11) ? ~last_grant_reg : pending[1];

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            be_reg         <= '0;
            wdata_reg      <= '0;
            bus_read_reg   <= 1'b0;
            bus_write_reg  <= 1'b0;
            grant_reg      <= 2'b00;
            last_grant_reg <= 1'b1;
            cnt_reg        <= '0;
            ack_reg        <= 2'b00;
            rdata_reg[0]   <= '0;
            rdata_reg[1]   <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (pending != 2'b00) begin
                        addr_reg       <= req_addr[winner];
                        be_reg         <= req_be[winner];
                        wdata_reg      <= req_wdata[winner];
                        // Read wins when a requester raises both strobes.
                        bus_read_reg   <= req_read[winner];
                        bus_write_reg  <= ~req_read[winner] & req_write[winner];
                        grant_reg      <= winner ? 2'b10 : 2'b01;
                        last_grant_reg <= winner;
                        cnt_reg        <= CNT_W'(1);
                        state_reg      <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // last_grant_reg names the current owner throughout BUS/RESP.
                    if (bridge_memory_acknowledge) begin
                        bus_read_reg              <= 1'b0;
                        bus_write_reg             <= 1'b0;
                        ack_reg[last_grant_reg]   <= 1'b1;
                        rdata_reg[last_grant_reg] <= bus_read_reg ? bridge_memory_read_data : '0;
                        state_reg                 <= ST_RESP;
                    end else if (cnt_reg == CNT_LIMIT) begin
                        bus_read_reg              <= 1'b0;
                        bus_write_reg             <= 1'b0;
                        ack_reg[last_grant_reg]   <= 1'b1;
                        rdata_reg[last_grant_reg] <= '0;
                        timeout_reg               <= 1'b1;
                        state_reg                 <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    ack_reg   <= 2'b00;
                    grant_reg <= 2'b00;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bridge_memory_address     = addr_reg;
    assign bridge_memory_byte_enable = be_reg;
    assign bridge_memory_read        = bus_read_reg;
    assign bridge_memory_write       = bus_write_reg;
    assign bridge_memory_write_data  = wdata_reg;
    assign m0_acknowledge            = ack_reg[0];
    assign m1_acknowledge            = ack_reg[1];
    assign m0_read_data              = rdata_reg[0];
    assign m1_read_data              = rdata_reg[1];
    assign grant                     = grant_reg;
    assign timeout_flag              = timeout_reg;

endmodule
